jpeg_idct_col_buffer: RTL and testbench
=======================================

# jpeg_idct_col_buffer

Ping-pong buffer between the IDCT transpose stage and the column-pass (Y) IDCT. It absorbs each 64-beat transpose burst, which cannot be stalled once started, and replays it to the column stage under a true per-beat valid/ready handshake. Two block-sized banks let one burst fill while the previous one drains, so a stalling downstream stage never loses data.

## Interface
Parameters:
- `DATA_W`, default 32: width of each of the four lanes per beat.
- `BEATS`, default 64: beats per block. Must be a power of two.

Ports:
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_i`  in  1  reset; asynchronous and active-high.
- `img_start_i`  in  1  synchronous flush at the start of an image.
- `inport_valid_i`  in  1  beat present from the transpose stage.
- `inport_data0_i`..`inport_data3_i`  in  DATA_W each  four lanes of the beat.
- `inport_idx_i`  in  3  beat index within an 8-beat group.
- `inport_ready_o`  out  1  a bank is free to take a full burst; it is sampled by upstream only at burst start.
- `outport_valid_o`  out  1  a beat is available.
- `outport_data0_o`..`outport_data3_o`  out  DATA_W each  four lanes of the beat.
- `outport_idx_o`  out  3  beat index, replayed as received.
- `outport_last_o`  out  1  final beat (BEATS-1) of the block.
- `outport_ready_i`  in  1  downstream accepts the beat.
- `error_o`  out  1  sticky protocol error. Present only with the configuration macro.

## Operation
- Storage: two banks, each BEATS × (4·DATA_W + 3) bits. Per-bank `full_q[1:0]`.
- Write pointer: `wr_bank_q` and `wr_cnt_q` (log2 BEATS bits).
  - An accepted write is `inport_valid_i && !full_q[wr_bank_q]`.
  - It stores lanes and idx at `[wr_bank_q][wr_cnt_q]` and increments `wr_cnt_q`.
  - On the write with `wr_cnt_q == BEATS-1`: set `full_q[wr_bank_q]`, toggle `wr_bank_q`, and wrap `wr_cnt_q` to 0.
- Read pointer: `rd_bank_q` and `rd_cnt_q`.
  - `outport_valid_o = full_q[rd_bank_q]`.
  - Outputs are read combinationally from `[rd_bank_q][rd_cnt_q]`.
  - `outport_last_o = outport_valid_o && rd_cnt_q == BEATS-1`.
  - A transfer is `outport_valid_o && outport_ready_i`. It increments `rd_cnt_q`.
  - On the last transfer: clear `full_q[rd_bank_q]`, toggle `rd_bank_q`, and wrap `rd_cnt_q`.
- `inport_ready_o = !full_q[wr_bank_q]`. It stays high while a bank is partially filled; upstream ignores it mid-burst.
- Simultaneous events:
  - Last write and last read in the same cycle act on different banks. Both flag updates take effect.
  - If the write completes into the bank being read, that is a protocol violation and cannot occur when `inport_ready_o` is honoured.
- A beat arriving while `full_q[wr_bank_q]` is set (overflow) is dropped and the pointers are unchanged.
- `img_start_i` has priority over all other updates. It clears `full_q`, all pointers and `error_o`. Data contents are don't-care.

## Timing
- Reset values:
  - `full_q` = 0, all pointers = 0.
  - `inport_ready_o` = 1, `outport_valid_o` = 0, `outport_last_o` = 0, `error_o` = 0.
  - Data and idx outputs are X-tolerant but driven from storage.
- Latency:
  - The last write beat is accepted at edge N.
  - `outport_valid_o` rises in the cycle after edge N, showing beat 0.
  - Minimum fill-to-first-output is 1 cycle.
- Throughput: 1 beat/cycle in and out. Sustained full rate needs no bubbles, because the banks alternate.
- No combinational path exists from `outport_ready_i` to `inport_ready_o`. `full_q` is registered.
- Reset is asynchronous at any point and abandons a partial burst. `img_start_i` mid-burst does the same synchronously.

## Configuration
- `JPEG_IDCT_COL_BUFFER_CHECK_EN` defined:
  - `error_o` exists.
  - It sets and holds on overflow (a write while `full_q[wr_bank_q]`).
  - It also sets and holds on an idx mismatch, i.e. a write with `inport_idx_i != wr_cnt_q[2:0]`. A mismatched beat is still stored.
  - `error_o` is cleared only by `rst_i` or `img_start_i`.
- Not defined: no `error_o` port and no check logic. Overflow beats are still dropped silently.

## Test plan
- Single burst: write 64 beats, lane0 = beat number, idx = n%8, with `outport_ready_i` = 1. Output shows beats 0..63 in order from the cycle after the last write. `outport_last_o` is high only on beat 63. Then `inport_ready_o` = 1.
- Back-to-back: three bursts with no gap and the output stalled. `inport_ready_o` drops after burst 2. Drain then shows bursts 1 and 2 intact. Burst 3 is accepted only after bank A empties.
- Random backpressure: `outport_ready_i` at 30% duty across 4 bursts. Every beat is delivered exactly once, in order, with matching idx.
- Simultaneous completion: time the last read of bank A with the last write of bank B. Next cycle, `full_q` = 2'b10, `rd_bank_q` = 1, and valid stays high.
- Flush: `img_start_i` at beat 20 of a burst with bank B full. Next cycle: valid = 0, ready = 1, and a new burst lands in bank A.
- With `JPEG_IDCT_COL_BUFFER_CHECK_EN`: send idx 5 at beat 3, then write while both banks are full. `error_o` rises on the idx write and stays high until `img_start_i`. The overflow beat never appears at the output.

Source files
------------

// File: rtl/jpeg_idct_col_buffer_if.sv
// jpeg_idct_col_buffer_if: beat bus between the transpose stage, the
// ping-pong column buffer and the column-pass IDCT. The master side is the
// surrounding pipeline (upstream writer plus downstream reader); the slave
// side is the buffer itself.
interface jpeg_idct_col_buffer_if #(
    parameter int DATA_W = 32
);
    logic              img_start_i;
    logic              inport_valid_i;
    logic [DATA_W-1:0] inport_data0_i;
    logic [DATA_W-1:0] inport_data1_i;
    logic [DATA_W-1:0] inport_data2_i;
    logic [DATA_W-1:0] inport_data3_i;
    logic [2:0]        inport_idx_i;
    logic              inport_ready_o;
    logic              outport_valid_o;
    logic [DATA_W-1:0] outport_data0_o;
    logic [DATA_W-1:0] outport_data1_o;
    logic [DATA_W-1:0] outport_data2_o;
    logic [DATA_W-1:0] outport_data3_o;
    logic [2:0]        outport_idx_o;
    logic              outport_last_o;
    logic              outport_ready_i;

    modport master (
        output img_start_i, inport_valid_i,
        output inport_data0_i, inport_data1_i, inport_data2_i, inport_data3_i,
        output inport_idx_i, outport_ready_i,
        input  inport_ready_o, outport_valid_o,
        input  outport_data0_o, outport_data1_o, outport_data2_o, outport_data3_o,
        input  outport_idx_o, outport_last_o
    );

    modport slave (
        input  img_start_i, inport_valid_i,
        input  inport_data0_i, inport_data1_i, inport_data2_i, inport_data3_i,
        input  inport_idx_i, outport_ready_i,
        output inport_ready_o, outport_valid_o,
        output outport_data0_o, outport_data1_o, outport_data2_o, outport_data3_o,
        output outport_idx_o, outport_last_o
    );
endinterface

// File: rtl/jpeg_idct_col_buffer.sv
// jpeg_idct_col_buffer: two-bank ping-pong buffer between the IDCT transpose
// stage (unstallable 64-beat bursts) and the column-pass IDCT (per-beat
// valid/ready). One bank fills while the other drains.
// Optional macro JPEG_IDCT_COL_BUFFER_CHECK_EN adds a sticky error_o that
// flags overflow writes and beat-index mismatches.
module jpeg_idct_col_buffer #(
    parameter int DATA_W = 32,
    parameter int BEATS  = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    jpeg_idct_col_buffer_if.slave bus
`ifdef JPEG_IDCT_COL_BUFFER_CHECK_EN
    ,
    output logic                 error_o
`endif
);
    localparam int CNT_W = $clog2(BEATS);
    localparam int ENT_W = 4 * DATA_W + 3;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    // Entry layout: {lane0, lane1, lane2, lane3, idx}; address {bank, cnt}
    logic [ENT_W-1:0] r_mem [2*BEATS];

    logic [1:0]       r_full;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [CNT_W-1:0] r_wr_cnt;
    logic [CNT_W-1:0] r_rd_cnt;

    logic             w_wr_acc;
    logic             w_wr_last;
    logic             w_rd_valid;
    logic             w_rd_xfer;
    logic             w_rd_last;
    logic [1:0]       w_full_nxt;
    logic [ENT_W-1:0] w_wr_ent;
    logic [ENT_W-1:0] w_rd_ent;

    assign w_wr_acc   = bus.inport_valid_i && !r_full[r_wr_bank];
    assign w_wr_last  = w_wr_acc && (r_wr_cnt == LAST_CNT);
    assign w_rd_valid = r_full[r_rd_bank];
    assign w_rd_xfer  = w_rd_valid && bus.outport_ready_i;
    assign w_rd_last  = w_rd_xfer && (r_rd_cnt == LAST_CNT);

    assign w_wr_ent = {bus.inport_data0_i, bus.inport_data1_i,
                       bus.inport_data2_i, bus.inport_data3_i, bus.inport_idx_i};
    assign w_rd_ent = r_mem[{r_rd_bank, r_rd_cnt}];

    assign bus.inport_ready_o  = !r_full[r_wr_bank];
    assign bus.outport_valid_o = w_rd_valid;
    assign bus.outport_last_o  = w_rd_valid && (r_rd_cnt == LAST_CNT);
    assign bus.outport_data0_o = w_rd_ent[ENT_W-1 -: DATA_W];
    assign bus.outport_data1_o = w_rd_ent[ENT_W-1-DATA_W -: DATA_W];
    assign bus.outport_data2_o = w_rd_ent[3+2*DATA_W-1 -: DATA_W];
    assign bus.outport_data3_o = w_rd_ent[3+DATA_W-1 -: DATA_W];
    assign bus.outport_idx_o   = w_rd_ent[2:0];

    // Bank flags: a completing read and a completing write hit different banks
    always_comb begin
        w_full_nxt = r_full;
        if (w_rd_last) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    // Beat storage; contents need no reset since full flags gate visibility
    always_ff @(posedge clk_i) begin
        if (w_wr_acc) begin
            r_mem[{r_wr_bank, r_wr_cnt}] <= w_wr_ent;
        end
    end

    // Pointers and flags; image start overrides any write/read in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
        end else if (bus.img_start_i) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_acc) begin
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_rd_xfer) begin
                r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                if (w_rd_last) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end
        end
    end

`ifdef JPEG_IDCT_COL_BUFFER_CHECK_EN
    logic r_error;
    logic w_err_evt;

    // Overflow, or a beat whose idx disagrees with its slot (beat still stored)
    assign w_err_evt = bus.inport_valid_i &&
                       (r_full[r_wr_bank] || (bus.inport_idx_i != r_wr_cnt[2:0]));
    assign error_o   = r_error;

    // Sticky protocol error, cleared only by reset or image start
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_error <= 1'b0;
        end else if (bus.img_start_i) begin
            r_error <= 1'b0;
        end else if (w_err_evt) begin
            r_error <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_jpeg_idct_col_buffer.sv
// tb_jpeg_idct_col_buffer: directed bench for the ping-pong column buffer.
// Beat words are {burst[7:0], lane[7:0], beat[15:0]}, so every lane of every
// beat is unique and expected values follow from burst/beat numbers alone.
module tb_jpeg_idct_col_buffer;
    localparam int DATA_W = 32;
    localparam int BEATS  = 64;
    localparam int EW     = 4 * DATA_W + 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    always #5 clk_i = ~clk_i;

    jpeg_idct_col_buffer_if #(.DATA_W(DATA_W)) bus ();

`ifdef JPEG_IDCT_COL_BUFFER_CHECK_EN
    logic error_o;
`endif

    jpeg_idct_col_buffer #(
        .DATA_W(DATA_W),
        .BEATS (BEATS)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .bus    (bus)
`ifdef JPEG_IDCT_COL_BUFFER_CHECK_EN
        ,
        .error_o(error_o)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [DATA_W-1:0] word(int b, int k, int n);
        return {8'(b), 8'(k), 16'(n)};
    endfunction

    // Expected {lane0..lane3, idx, last} for beat n of burst b
    function automatic logic [EW-1:0] exp_beat(int b, int n);
        return {word(b, 0, n), word(b, 1, n), word(b, 2, n), word(b, 3, n),
                3'(n % 8), (n == BEATS - 1)};
    endfunction

    function automatic logic [EW-1:0] act_beat();
        return {bus.outport_data0_o, bus.outport_data1_o, bus.outport_data2_o,
                bus.outport_data3_o, bus.outport_idx_o, bus.outport_last_o};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_beat(int b, int n, logic [2:0] idx);
        bus.inport_valid_i = 1'b1;
        bus.inport_data0_i = word(b, 0, n);
        bus.inport_data1_i = word(b, 1, n);
        bus.inport_data2_i = word(b, 2, n);
        bus.inport_data3_i = word(b, 3, n);
        bus.inport_idx_i   = idx;
    endtask

    task automatic test_reset();
        bus.img_start_i     = 1'b0;
        bus.inport_valid_i  = 1'b0;
        bus.inport_data0_i  = '0;
        bus.inport_data1_i  = '0;
        bus.inport_data2_i  = '0;
        bus.inport_data3_i  = '0;
        bus.inport_idx_i    = '0;
        bus.outport_ready_i = 1'b0;
        #1 rst_i = 1'b1;
        #1;
        vectors++;
        if ({bus.inport_ready_o, bus.outport_valid_o, bus.outport_last_o} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_flags: got rdy/vld/last=%b expected 100",
                     {bus.inport_ready_o, bus.outport_valid_o, bus.outport_last_o});
        end
`ifdef JPEG_IDCT_COL_BUFFER_CHECK_EN
        vectors++;
        if (error_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_error: got %b expected 0", error_o);
        end
`endif
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        vectors++;
        if ({bus.inport_ready_o, bus.outport_valid_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL post_reset: got rdy/vld=%b expected 10",
                     {bus.inport_ready_o, bus.outport_valid_o});
        end
    endtask

    task automatic test_single_burst();
        bus.outport_ready_i = 1'b1;
        for (int n = 0; n < BEATS; n++) begin
            drive_beat(0, n, 3'(n % 8));
            if (n == BEATS - 1) begin
                vectors++;
                if (bus.outport_valid_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL single_early_valid: got %b expected 0", bus.outport_valid_o);
                end
            end
            tick();
        end
        bus.inport_valid_i = 1'b0;
        for (int n = 0; n < BEATS; n++) begin
            vectors++;
            if ({bus.outport_valid_o, act_beat()} !== {1'b1, exp_beat(0, n)}) begin
                miscompares++;
                $display("FAIL single_beat%0d: got %h expected %h", n,
                         {bus.outport_valid_o, act_beat()}, {1'b1, exp_beat(0, n)});
            end
            tick();
        end
        vectors++;
        if ({bus.inport_ready_o, bus.outport_valid_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_end: got rdy/vld=%b expected 10",
                     {bus.inport_ready_o, bus.outport_valid_o});
        end
        bus.outport_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.outport_ready_i = 1'b0;
        for (int n = 0; n < BEATS; n++) begin
            drive_beat(1, n, 3'(n % 8));
            tick();
        end
        vectors++;
        if (bus.inport_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready_after1: got %b expected 1", bus.inport_ready_o);
        end
        for (int n = 0; n < BEATS; n++) begin
            drive_beat(2, n, 3'(n % 8));
            tick();
        end
        bus.inport_valid_i = 1'b0;
        tick();
        tick();
        vectors++;
        if ({bus.inport_ready_o, bus.outport_valid_o, act_beat()} !== {2'b01, exp_beat(1, 0)}) begin
            miscompares++;
            $display("FAIL b2b_stalled: got %h expected %h",
                     {bus.inport_ready_o, bus.outport_valid_o, act_beat()}, {2'b01, exp_beat(1, 0)});
        end
        bus.outport_ready_i = 1'b1;
        for (int n = 0; n < BEATS; n++) begin
            vectors++;
            if ({bus.inport_ready_o, bus.outport_valid_o, act_beat()} !== {2'b01, exp_beat(1, n)}) begin
                miscompares++;
                $display("FAIL b2b_drain1_beat%0d: got %h expected %h", n,
                         {bus.inport_ready_o, bus.outport_valid_o, act_beat()}, {2'b01, exp_beat(1, n)});
            end
            tick();
        end
        vectors++;
        if ({bus.inport_ready_o, bus.outport_valid_o, act_beat()} !== {2'b11, exp_beat(2, 0)}) begin
            miscompares++;
            $display("FAIL b2b_bankA_free: got %h expected %h",
                     {bus.inport_ready_o, bus.outport_valid_o, act_beat()}, {2'b11, exp_beat(2, 0)});
        end
        for (int n = 0; n < BEATS; n++) begin
            drive_beat(3, n, 3'(n % 8));
            vectors++;
            if ({bus.outport_valid_o, act_beat()} !== {1'b1, exp_beat(2, n)}) begin
                miscompares++;
                $display("FAIL b2b_drain2_beat%0d: got %h expected %h", n,
                         {bus.outport_valid_o, act_beat()}, {1'b1, exp_beat(2, n)});
            end
            tick();
        end
        bus.inport_valid_i = 1'b0;
        for (int n = 0; n < BEATS; n++) begin
            vectors++;
            if ({bus.outport_valid_o, act_beat()} !== {1'b1, exp_beat(3, n)}) begin
                miscompares++;
                $display("FAIL b2b_drain3_beat%0d: got %h expected %h", n,
                         {bus.outport_valid_o, act_beat()}, {1'b1, exp_beat(3, n)});
            end
            tick();
        end
        vectors++;
        if (bus.outport_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_empty: got %b expected 0", bus.outport_valid_o);
        end
        bus.outport_ready_i = 1'b0;
    endtask

    task automatic test_random_backpressure();
        int wb = 0;
        int wn = 0;
        int rb = 0;
        int rn = 0;
        int cyc = 0;
        bit in_b = 1'b0;
        while (rb < 4 && cyc < 4000) begin
            bus.outport_ready_i = ($urandom_range(0, 99) < 30);
            if (bus.outport_valid_o && bus.outport_ready_i) begin
                vectors++;
                if (act_beat() !== exp_beat(10 + rb, rn)) begin
                    miscompares++;
                    $display("FAIL rand_b%0d_beat%0d: got %h expected %h", rb, rn,
                             act_beat(), exp_beat(10 + rb, rn));
                end
                rn++;
                if (rn == BEATS) begin
                    rn = 0;
                    rb++;
                end
            end
            if (!in_b && wb < 4 && bus.inport_ready_o) begin
                in_b = 1'b1;
                wn   = 0;
            end
            if (in_b) begin
                drive_beat(10 + wb, wn, 3'(wn % 8));
                wn++;
                if (wn == BEATS) begin
                    in_b = 1'b0;
                    wb++;
                end
            end else begin
                bus.inport_valid_i = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.inport_valid_i  = 1'b0;
        bus.outport_ready_i = 1'b0;
        vectors++;
        if (rb != 4 || bus.outport_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_complete: got bursts=%0d vld=%b expected bursts=4 vld=0",
                     rb, bus.outport_valid_o);
        end
    endtask

    task automatic test_simultaneous();
        bus.outport_ready_i = 1'b0;
        for (int n = 0; n < BEATS; n++) begin
            drive_beat(20, n, 3'(n % 8));
            tick();
        end
        bus.outport_ready_i = 1'b1;
        for (int n = 0; n < BEATS; n++) begin
            drive_beat(21, n, 3'(n % 8));
            vectors++;
            if ({bus.outport_valid_o, act_beat()} !== {1'b1, exp_beat(20, n)}) begin
                miscompares++;
                $display("FAIL simul_beat%0d: got %h expected %h", n,
                         {bus.outport_valid_o, act_beat()}, {1'b1, exp_beat(20, n)});
            end
            tick();
        end
        bus.inport_valid_i  = 1'b0;
        bus.outport_ready_i = 1'b0;
        vectors++;
        if ({dut.r_full, dut.r_rd_bank, bus.outport_valid_o, act_beat()} !==
            {2'b10, 1'b1, 1'b1, exp_beat(21, 0)}) begin
            miscompares++;
            $display("FAIL simul_state: got %h expected %h",
                     {dut.r_full, dut.r_rd_bank, bus.outport_valid_o, act_beat()},
                     {2'b10, 1'b1, 1'b1, exp_beat(21, 0)});
        end
    endtask

    task automatic test_flush();
        bus.outport_ready_i = 1'b0;
        for (int n = 0; n < 20; n++) begin
            drive_beat(22, n, 3'(n % 8));
            tick();
        end
        drive_beat(22, 20, 3'(20 % 8));
        bus.img_start_i = 1'b1;
        tick();
        bus.img_start_i    = 1'b0;
        bus.inport_valid_i = 1'b0;
        vectors++;
        if ({bus.outport_valid_o, bus.inport_ready_o} !== 2'b01) begin
            miscompares++;
            $display("FAIL flush_flags: got vld/rdy=%b expected 01",
                     {bus.outport_valid_o, bus.inport_ready_o});
        end
        for (int n = 0; n < BEATS; n++) begin
            drive_beat(23, n, 3'(n % 8));
            tick();
        end
        bus.inport_valid_i = 1'b0;
        vectors++;
        if ({dut.r_full, dut.r_rd_bank, bus.outport_valid_o, act_beat()} !==
            {2'b01, 1'b0, 1'b1, exp_beat(23, 0)}) begin
            miscompares++;
            $display("FAIL flush_bankA: got %h expected %h",
                     {dut.r_full, dut.r_rd_bank, bus.outport_valid_o, act_beat()},
                     {2'b01, 1'b0, 1'b1, exp_beat(23, 0)});
        end
        bus.outport_ready_i = 1'b1;
        for (int n = 0; n < BEATS; n++) begin
            vectors++;
            if ({bus.outport_valid_o, act_beat()} !== {1'b1, exp_beat(23, n)}) begin
                miscompares++;
                $display("FAIL flush_beat%0d: got %h expected %h", n,
                         {bus.outport_valid_o, act_beat()}, {1'b1, exp_beat(23, n)});
            end
            tick();
        end
        bus.outport_ready_i = 1'b0;
        vectors++;
        if (bus.outport_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_empty: got %b expected 0", bus.outport_valid_o);
        end
    endtask

`ifdef JPEG_IDCT_COL_BUFFER_CHECK_EN
    task automatic test_check_en();
        logic [EW-1:0] e;
        vectors++;
        if (error_o !== 1'b0) begin
            miscompares++;
            $display("FAIL chk_initial: got %b expected 0", error_o);
        end
        bus.outport_ready_i = 1'b0;
        for (int n = 0; n < BEATS; n++) begin
            drive_beat(30, n, (n == 3) ? 3'd5 : 3'(n % 8));
            tick();
            if (n == 2 || n == 3) begin
                vectors++;
                if (error_o !== (n == 3)) begin
                    miscompares++;
                    $display("FAIL chk_idx_beat%0d: got %b expected %b", n, error_o, (n == 3));
                end
            end
        end
        for (int n = 0; n < BEATS; n++) begin
            drive_beat(31, n, 3'(n % 8));
            tick();
        end
        drive_beat(32, 0, 3'd0);
        tick();
        bus.inport_valid_i = 1'b0;
        vectors++;
        if ({error_o, bus.inport_ready_o, bus.outport_valid_o} !== 3'b101) begin
            miscompares++;
            $display("FAIL chk_overflow: got err/rdy/vld=%b expected 101",
                     {error_o, bus.inport_ready_o, bus.outport_valid_o});
        end
        bus.outport_ready_i = 1'b1;
        for (int n = 0; n < BEATS; n++) begin
            e = exp_beat(30, n);
            if (n == 3) e[3:1] = 3'd5;
            vectors++;
            if ({bus.outport_valid_o, act_beat()} !== {1'b1, e}) begin
                miscompares++;
                $display("FAIL chk_drain30_beat%0d: got %h expected %h", n,
                         {bus.outport_valid_o, act_beat()}, {1'b1, e});
            end
            tick();
        end
        for (int n = 0; n < BEATS; n++) begin
            vectors++;
            if ({bus.outport_valid_o, act_beat()} !== {1'b1, exp_beat(31, n)}) begin
                miscompares++;
                $display("FAIL chk_drain31_beat%0d: got %h expected %h", n,
                         {bus.outport_valid_o, act_beat()}, {1'b1, exp_beat(31, n)});
            end
            tick();
        end
        bus.outport_ready_i = 1'b0;
        vectors++;
        if ({bus.outport_valid_o, error_o} !== 2'b01) begin
            miscompares++;
            $display("FAIL chk_after_drain: got vld/err=%b expected 01",
                     {bus.outport_valid_o, error_o});
        end
        bus.img_start_i = 1'b1;
        tick();
        bus.img_start_i = 1'b0;
        vectors++;
        if (error_o !== 1'b0) begin
            miscompares++;
            $display("FAIL chk_clear: got %b expected 0", error_o);
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_random_backpressure();
        test_simultaneous();
        test_flush();
`ifdef JPEG_IDCT_COL_BUFFER_CHECK_EN
        test_check_en();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
